// File: rtl/dwc_retry_controller.sv
// -----------------------------------------------------------------------------
// dwc_retry_controller
//
// Sequences operands into a duplicated-with-comparison (DwC) combinational unit.
// A request is captured over a valid/ready handshake and registered onto
// port_dwc_in. After one settling cycle the replica result and comparator flag
// are sampled. On a mismatch the unit is flushed with zeros for one cycle and
// re-executed, up to MAX_RETRY extra attempts. A clean attempt returns the
// primary replica result. Exhausting all attempts returns a fault response,
// and completing that response raises the sticky fatal flag. The controller
// then refuses work until port_clear.
//
// Ports:
//   port_clk, port_rst_n        clock (rising edge), async active-low reset
//   port_req_valid/ready/data   operand request handshake
//   port_dwc_in                 registered operand driven into the DwC unit
//   port_dwc_out, port_dwc_error primary replica result and comparator output
//   port_rsp_valid/ready        response handshake
//   port_rsp_data, port_rsp_fault registered result and fault indication
//   port_err_count              saturating count of all mismatches seen
//   port_fatal                  sticky fatal flag for the system fault monitor
//   port_clear                  synchronous clear of port_err_count/port_fatal
// -----------------------------------------------------------------------------
module dwc_retry_controller #(
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter bit          ERR_ACTIVE = 1'b1
) (
    input  logic                 port_clk,
    input  logic                 port_rst_n,
    input  logic                 port_req_valid,
    output logic                 port_req_ready,
    input  logic [DATA_W-1:0]    port_req_data,
    output logic [DATA_W-1:0]    port_dwc_in,
    input  logic                 port_dwc_out,
    input  logic                 port_dwc_error,
    output logic                 port_rsp_valid,
    input  logic                 port_rsp_ready,
    output logic                 port_rsp_data,
    output logic                 port_rsp_fault,
    output logic [ERR_CNT_W-1:0] port_err_count,
    output logic                 port_fatal,
    input  logic                 port_clear
);

    // MAX_RETRY is limited to 0..15, so a 4-bit retry counter always suffices.
    localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RETRY,
        S_RESP,
        S_FATAL
    } state_e;

    state_e                state_q,     state_d;
    logic [DATA_W-1:0]     op_q,        op_d;
    logic [DATA_W-1:0]     dwc_in_q,    dwc_in_d;
    logic [3:0]            retry_q,     retry_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_data_q,  rsp_data_d;
    logic                  rsp_fault_q, rsp_fault_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  fatal_q,     fatal_d;

    logic                  mismatch;
    logic [ERR_CNT_W-1:0]  err_base;

    // The comparator polarity is a parameter; the replica result is ignored
    // whenever this reports disagreement.
    assign mismatch = (port_dwc_error == ERR_ACTIVE);

    // Clear takes effect first, so a mismatch on the same edge counts from 0.
    assign err_base = port_clear ? '0 : err_count_q;

    // NOTE: every _d signal gets its hold value before the case statement, so
    // no path through the logic leaves a variable unassigned and no latch is
    // inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dwc_in_d    = dwc_in_q;
        retry_d     = retry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        err_count_d = err_base;
        fatal_d     = port_clear ? 1'b0 : fatal_q;

        case (state_q)
            S_IDLE: begin
                dwc_in_d = '0;
                if (port_req_valid) begin
                    op_d     = port_req_data;
                    dwc_in_d = port_req_data;
                    retry_d  = '0;
                    state_d  = S_EXEC;
                end
            end

            // The unit has had a full cycle to settle on the registered operand.
            S_EXEC: begin
                if (mismatch) begin
                    err_count_d = (&err_base) ? err_base : err_base + ERR_CNT_W'(1);
                    if (retry_q < MAX_RETRY_L) begin
                        retry_d  = retry_q + 4'd1;
                        dwc_in_d = '0;
                        state_d  = S_RETRY;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 1'b0;
                        rsp_fault_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = port_dwc_out;
                    rsp_fault_d = 1'b0;
                    state_d     = S_RESP;
                end
            end

            // One cycle of zeros flushes any transient state in the replicas
            // before the captured operand is applied again.
            S_RETRY: begin
                dwc_in_d = op_q;
                state_d  = S_EXEC;
            end

            S_RESP: begin
                if (port_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    dwc_in_d    = '0;
                    if (rsp_fault_q) begin
                        // A completed fault response wins over a coincident clear.
                        fatal_d = 1'b1;
                        state_d = S_FATAL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_FATAL: begin
                if (port_clear) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is only ever updated with non-blocking assignments here, so
    // every flop samples the values from before the edge regardless of order.
    always_ff @(posedge port_clk or negedge port_rst_n) begin
        if (!port_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            dwc_in_q    <= '0;
            retry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            rsp_fault_q <= 1'b0;
            err_count_q <= '0;
            fatal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dwc_in_q    <= dwc_in_d;
            retry_q     <= retry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            err_count_q <= err_count_d;
            fatal_q     <= fatal_d;
        end
    end

    // Ready is the only output that is decoded rather than registered; it
    // depends on the state register alone.
    assign port_req_ready = (state_q == S_IDLE);
    assign port_dwc_in    = dwc_in_q;
    assign port_rsp_valid = rsp_valid_q;
    assign port_rsp_data  = rsp_data_q;
    assign port_rsp_fault = rsp_fault_q;
    assign port_err_count = err_count_q;
    assign port_fatal     = fatal_q;

endmodule

// File: tb/tb_dwc_retry_controller.sv
// Self-checking bench for dwc_retry_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model.
module tb_dwc_retry_controller;

    localparam int unsigned DATA_W     = 2;
    localparam int unsigned MAX_RETRY  = 3;
    localparam int unsigned ERR_CNT_W  = 3;
    localparam bit          ERR_ACTIVE = 1'b1;
    localparam int unsigned CNT_MAX    = (1 << ERR_CNT_W) - 1;

    logic                 port_clk = 1'b0;
    logic                 port_rst_n = 1'b0;
    logic                 port_req_valid;
    logic                 port_req_ready;
    logic [DATA_W-1:0]    port_req_data;
    logic [DATA_W-1:0]    port_dwc_in;
    logic                 port_dwc_out;
    logic                 port_dwc_error;
    logic                 port_rsp_valid;
    logic                 port_rsp_ready;
    logic                 port_rsp_data;
    logic                 port_rsp_fault;
    logic [ERR_CNT_W-1:0] port_err_count;
    logic                 port_fatal;
    logic                 port_clear;

    // The DwC unit stand-in: an AND of the operand bits, or a random bit to
    // show the controller ignores the result on a mismatch.
    logic use_and;
    logic rnd_out;
    assign port_dwc_out = use_and ? (&port_dwc_in) : rnd_out;

    always #5 port_clk = ~port_clk;

    dwc_retry_controller #(
        .DATA_W    (DATA_W),
        .MAX_RETRY (MAX_RETRY),
        .ERR_CNT_W (ERR_CNT_W),
        .ERR_ACTIVE(ERR_ACTIVE)
    ) dut (
        .port_clk      (port_clk),
        .port_rst_n    (port_rst_n),
        .port_req_valid(port_req_valid),
        .port_req_ready(port_req_ready),
        .port_req_data (port_req_data),
        .port_dwc_in   (port_dwc_in),
        .port_dwc_out  (port_dwc_out),
        .port_dwc_error(port_dwc_error),
        .port_rsp_valid(port_rsp_valid),
        .port_rsp_ready(port_rsp_ready),
        .port_rsp_data (port_rsp_data),
        .port_rsp_fault(port_rsp_fault),
        .port_err_count(port_err_count),
        .port_fatal    (port_fatal),
        .port_clear    (port_clear)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge port_clk);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model. An operation in flight is described by its
    // age (edges since accept) and the number of retries used: execution
    // windows fall on even ages, flush windows on odd ages.
    // ------------------------------------------------------------------
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    bit                m_halted = 1'b0;
    int                m_age = 0;
    int                m_retries = 0;
    int unsigned       m_count = 0;
    logic [DATA_W-1:0] m_op = '0;

    logic              exp_ready = 1'b1;
    logic [DATA_W-1:0] exp_dwc_in = '0;
    logic              exp_rsp_valid = 1'b0;
    logic              exp_rsp_data = 1'b0;
    logic              exp_rsp_fault = 1'b0;
    logic              exp_fatal = 1'b0;

    always @(posedge port_clk or negedge port_rst_n) begin
        if (!port_rst_n) begin
            m_busy = 0; m_resp = 0; m_halted = 0;
            m_age = 0; m_retries = 0; m_count = 0; m_op = '0;
            exp_ready = 1'b1; exp_dwc_in = '0; exp_rsp_valid = 1'b0;
            exp_rsp_data = 1'b0; exp_rsp_fault = 1'b0; exp_fatal = 1'b0;
        end else begin
            if (port_clear) begin
                m_count = 0;
                exp_fatal = 1'b0;
            end
            if (m_busy) begin
                if (m_age % 2 == 0) begin
                    if (port_dwc_error == ERR_ACTIVE) begin
                        m_count = (m_count >= CNT_MAX) ? CNT_MAX : m_count + 1;
                        if (m_retries < MAX_RETRY) begin
                            m_retries++;
                            m_age++;
                            exp_dwc_in = '0;
                        end else begin
                            m_busy = 0; m_resp = 1;
                            exp_rsp_valid = 1'b1; exp_rsp_fault = 1'b1; exp_rsp_data = 1'b0;
                        end
                    end else begin
                        m_busy = 0; m_resp = 1;
                        exp_rsp_valid = 1'b1; exp_rsp_fault = 1'b0; exp_rsp_data = port_dwc_out;
                    end
                end else begin
                    m_age++;
                    exp_dwc_in = m_op;
                end
            end else if (m_resp) begin
                if (port_rsp_ready) begin
                    m_resp = 0;
                    exp_rsp_valid = 1'b0;
                    exp_dwc_in = '0;
                    if (exp_rsp_fault) begin
                        exp_fatal = 1'b1;
                        m_halted = 1;
                    end
                end
            end else if (m_halted) begin
                if (port_clear) m_halted = 0;
            end else begin
                if (port_req_valid) begin
                    m_busy = 1; m_age = 0; m_retries = 0;
                    m_op = port_req_data;
                    exp_dwc_in = port_req_data;
                end else begin
                    exp_dwc_in = '0;
                end
            end
            exp_ready = !(m_busy || m_resp || m_halted);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge port_clk) begin
        check("cmp_req_ready", 32'(port_req_ready), 32'(exp_ready));
        check("cmp_dwc_in",    32'(port_dwc_in),    32'(exp_dwc_in));
        check("cmp_rsp_valid", 32'(port_rsp_valid), 32'(exp_rsp_valid));
        check("cmp_err_count", 32'(port_err_count), 32'(m_count));
        check("cmp_fatal",     32'(port_fatal),     32'(exp_fatal));
        if (exp_rsp_valid) begin
            check("cmp_rsp_data",  32'(port_rsp_data),  32'(exp_rsp_data));
            check("cmp_rsp_fault", 32'(port_rsp_fault), 32'(exp_rsp_fault));
        end
    end

    // Mismatch on the first execution only; optional clear on that same edge.
    task automatic run_transient(input logic [DATA_W-1:0] data, input bit clr_on_mismatch);
        port_req_valid = 1'b1; port_req_data = data;
        cyc(1);
        port_req_valid = 1'b0; port_dwc_error = 1'b1; port_clear = clr_on_mismatch;
        cyc(1);
        port_dwc_error = 1'b0; port_clear = 1'b0;
        cyc(2);
        port_rsp_ready = 1'b1;
        cyc(1);
        port_rsp_ready = 1'b0;
    endtask

    initial begin
        port_req_valid = 1'b0; port_req_data = '0; port_dwc_error = 1'b0;
        port_rsp_ready = 1'b0; port_clear = 1'b0; use_and = 1'b1; rnd_out = 1'b0;

        // Reset state
        cyc(1);
        check("rst_ready",     32'(port_req_ready), 1);
        check("rst_dwc_in",    32'(port_dwc_in),    0);
        check("rst_rsp_valid", 32'(port_rsp_valid), 0);
        check("rst_count",     32'(port_err_count), 0);
        check("rst_fatal",     32'(port_fatal),     0);
        port_rst_n = 1'b1;
        cyc(1);

        // Clean operation: operand 11, response seen at accept edge + 2
        port_req_valid = 1'b1; port_req_data = 2'b11;
        cyc(1);
        port_req_valid = 1'b0;
        check("clean_dwc_in",  32'(port_dwc_in),    3);
        check("clean_early",   32'(port_rsp_valid), 0);
        cyc(1);
        check("clean_valid",   32'(port_rsp_valid), 1);
        check("clean_data",    32'(port_rsp_data),  1);
        check("clean_fault",   32'(port_rsp_fault), 0);
        check("clean_count",   32'(port_err_count), 0);
        port_rsp_ready = 1'b1;
        cyc(1);
        port_rsp_ready = 1'b0;
        check("clean_done",    32'(port_rsp_valid), 0);
        check("clean_ready",   32'(port_req_ready), 1);

        // Transient fault: dwc_in goes 11, 00, 11; response at accept edge + 4
        port_req_valid = 1'b1; port_req_data = 2'b11;
        cyc(1);
        port_req_valid = 1'b0; port_dwc_error = 1'b1;
        check("tr_dwc_in0",    32'(port_dwc_in), 3);
        cyc(1);
        port_dwc_error = 1'b0;
        check("tr_flush",      32'(port_dwc_in),    0);
        check("tr_count_mid",  32'(port_err_count), 1);
        cyc(1);
        check("tr_reload",     32'(port_dwc_in),    3);
        check("tr_early",      32'(port_rsp_valid), 0);
        cyc(1);
        check("tr_valid",      32'(port_rsp_valid), 1);
        check("tr_data",       32'(port_rsp_data),  1);
        check("tr_fault",      32'(port_rsp_fault), 0);
        check("tr_count",      32'(port_err_count), 1);
        port_rsp_ready = 1'b1;
        cyc(1);
        port_rsp_ready = 1'b0;

        // Permanent fault: four executions, fault response at accept edge + 8
        port_clear = 1'b1;
        cyc(1);
        port_clear = 1'b0;
        check("pf_cleared",    32'(port_err_count), 0);
        port_dwc_error = 1'b1; port_req_valid = 1'b1; port_req_data = 2'b11;
        cyc(1);
        port_req_valid = 1'b0;
        cyc(6);
        check("pf_early",      32'(port_rsp_valid), 0);
        cyc(1);
        check("pf_valid",      32'(port_rsp_valid), 1);
        check("pf_fault",      32'(port_rsp_fault), 1);
        check("pf_data",       32'(port_rsp_data),  0);
        check("pf_count",      32'(port_err_count), 4);

        // Backpressure: response held stable, no accept despite req_valid
        port_req_valid = 1'b1; port_req_data = 2'b01;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("bp_valid", 32'(port_rsp_valid), 1);
            check("bp_fault", 32'(port_rsp_fault), 1);
            check("bp_data",  32'(port_rsp_data),  0);
            check("bp_ready", 32'(port_req_ready), 0);
        end
        port_rsp_ready = 1'b1;
        cyc(1);
        port_rsp_ready = 1'b0; port_dwc_error = 1'b0;
        check("pf_fatal",      32'(port_fatal),     1);
        check("pf_halt_ready", 32'(port_req_ready), 0);
        check("pf_rsp_done",   32'(port_rsp_valid), 0);
        cyc(2);
        check("pf_still_halt", 32'(port_req_ready), 0);
        port_clear = 1'b1; port_req_valid = 1'b0;
        cyc(1);
        port_clear = 1'b0;
        check("pf_clr_fatal",  32'(port_fatal),     0);
        check("pf_clr_count",  32'(port_err_count), 0);
        check("pf_clr_ready",  32'(port_req_ready), 1);

        // Saturation, then clear colliding with a mismatch edge
        for (int i = 0; i < 8; i++) begin
            run_transient(DATA_W'(i), 1'b0);
            check("sat_step", 32'(port_err_count), (i + 1 > 7) ? 7 : i + 1);
        end
        check("sat_hold",      32'(port_err_count), 7);
        run_transient(2'b10, 1'b1);
        check("clr_collide",   32'(port_err_count), 1);

        // Reset during the flush window
        port_req_valid = 1'b1; port_req_data = 2'b11;
        cyc(1);
        port_req_valid = 1'b0; port_dwc_error = 1'b1;
        cyc(1);
        port_dwc_error = 1'b0;
        #2 port_rst_n = 1'b0;
        #1;
        check("mr_dwc_in",     32'(port_dwc_in),    0);
        check("mr_rsp_valid",  32'(port_rsp_valid), 0);
        check("mr_ready",      32'(port_req_ready), 1);
        check("mr_count",      32'(port_err_count), 0);
        check("mr_fatal",      32'(port_fatal),     0);
        cyc(1);
        port_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("mr_no_rsp", 32'(port_rsp_valid), 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            port_req_valid = 1'($urandom_range(0, 1));
            port_req_data  = DATA_W'($urandom);
            port_dwc_error = ($urandom_range(0, 9) < 3);
            port_rsp_ready = 1'($urandom_range(0, 1));
            port_clear     = ($urandom_range(0, 49) == 0);
            use_and        = 1'($urandom_range(0, 1));
            rnd_out        = 1'($urandom_range(0, 1));
            cyc(1);
        end

        port_req_valid = 1'b0; port_clear = 1'b0; port_rsp_ready = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
